disp_fill_median: RTL and testbench

- Downstream consumer of the direction-fill register stage in the post-processing chain.
- Takes the packed 3-direction word (135/90/45 lanes, each {mismatch, occlusion, disparity}) plus its valid strobe.
- Per lane, replaces flagged pixels with that lane's last valid disparity in the current line, then fuses the three lanes with a median-of-3.
- Emits one final disparity per pixel, an end-of-line tag and per-line hole statistics.

---
 rtl/pp_pkg.sv | 33 +++
 rtl/disp_lane_fill.sv | 36 +++
 rtl/disp_fill_median.sv | 181 ++++++++++++++++++
 tb/tb_disp_fill_median.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pp_pkg.sv
// Shared definitions for the disparity post-processing chain: lane layout,
// lane indices and the median-of-3 selector.
package pp_pkg;

    localparam int L45  = 0;
    localparam int L90  = 1;
    localparam int L135 = 2;

    // Widest disparity the median selector handles; callers zero-extend.
    localparam int MW = 16;

    function automatic int mismatch_bit(input int dwidth);
        return dwidth + 1;
    endfunction

    function automatic int occl_bit(input int dwidth);
        return dwidth;
    endfunction

    // Returns which operand (0=a, 1=b, 2=c) is the unsigned median; ties
    // land on an operand equal to the median value.
    function automatic logic [1:0] median3_sel(input logic [MW-1:0] a,
                                               input logic [MW-1:0] b,
                                               input logic [MW-1:0] c);
        if ((a >= b && a <= c) || (a <= b && a >= c))
            return 2'd0;
        else if ((b >= a && b <= c) || (b <= a && b >= c))
            return 2'd1;
        else
            return 2'd2;
    endfunction

endpackage

// File: rtl/disp_lane_fill.sv
// One direction lane: remembers the last valid disparity of the current line
// and substitutes it for flagged pixels.
module disp_lane_fill
    import pp_pkg::*;
#(
    parameter int DWIDTH = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clken,
    input  logic              din_valid,
    input  logic              col_zero,
    input  logic [DWIDTH+1:0] lane,
    output logic [DWIDTH-1:0] filled,
    output logic              flagged
);

    localparam int MIS_BIT = mismatch_bit(DWIDTH);
    localparam int OCC_BIT = occl_bit(DWIDTH);

    logic [DWIDTH-1:0] last_valid;

    assign flagged = lane[MIS_BIT] | lane[OCC_BIT];

    // At column 0 the stored value belongs to the previous line, so use 0.
    assign filled = !flagged ? lane[DWIDTH-1:0] :
                    (col_zero ? '0 : last_valid);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_valid <= '0;
        else if (clken && din_valid && !flagged)
            last_valid <= lane[DWIDTH-1:0];
    end

endmodule

// File: rtl/disp_fill_median.sv
// Per-lane hole fill, median-of-3 lane fusion and per-line hole statistics.
// Define DISP_HMEDIAN_EN to add a causal 3-tap horizontal median stage.
module disp_fill_median
    import pp_pkg::*;
#(
    parameter int DWIDTH    = 7,
    parameter int IMG_WIDTH = 640
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clken,
    input  logic [3*DWIDTH+5:0]            din_overall,
    input  logic                           din_valid,
    output logic [DWIDTH-1:0]              dout,
    output logic                           dout_hole,
    output logic                           dout_valid,
    output logic                           dout_eol,
    output logic [$clog2(IMG_WIDTH):0]     line_hole_cnt,
    output logic                           line_stat_valid
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int AW = CW + 1;
    localparam int LW = DWIDTH + 2;

    function automatic logic [DWIDTH-1:0] med(input logic [DWIDTH-1:0] a,
                                              input logic [DWIDTH-1:0] b,
                                              input logic [DWIDTH-1:0] c);
        case (median3_sel(MW'(a), MW'(b), MW'(c)))
            2'd0:    return a;
            2'd1:    return b;
            default: return c;
        endcase
    endfunction

    logic          accept;
    logic [CW-1:0] col;
    logic          col_zero;
    logic          eol;

    assign accept   = clken & din_valid;
    assign col_zero = (col == '0);
    assign eol      = (col == CW'(IMG_WIDTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            col <= '0;
        else if (accept)
            col <= eol ? '0 : col + 1'b1;
    end

    // Lane index i sits at din_overall[i*LW +: LW] (L45 lowest, L135 highest).
    logic [DWIDTH-1:0] filled [3];
    logic [2:0]        flagged;

    for (genvar i = 0; i < 3; i++) begin : g_lane
        disp_lane_fill #(.DWIDTH(DWIDTH)) u_fill (
            .clk       (clk),
            .rst       (rst),
            .clken     (clken),
            .din_valid (din_valid),
            .col_zero  (col_zero),
            .lane      (din_overall[i*LW +: LW]),
            .filled    (filled[i]),
            .flagged   (flagged[i])
        );
    end

    logic              s1_valid;
    logic [DWIDTH-1:0] s1_fill [3];
    logic              s1_hole;
    logic              s1_eol;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_fill  <= '{default: '0};
            s1_hole  <= 1'b0;
            s1_eol   <= 1'b0;
        end else if (clken) begin
            s1_valid <= din_valid;
            if (din_valid) begin
                s1_fill <= filled;
                s1_hole <= &flagged;
                s1_eol  <= eol;
            end
        end
    end

    logic [DWIDTH-1:0] fused;
    assign fused = med(s1_fill[L45], s1_fill[L90], s1_fill[L135]);

    logic              o_valid;
    logic [DWIDTH-1:0] o_dat;
    logic              o_hole;
    logic              o_eol;

`ifdef DISP_HMEDIAN_EN
    logic              s1_first;
    logic              s2_valid;
    logic [DWIDTH-1:0] s2_fused;
    logic              s2_hole;
    logic              s2_eol;
    logic              s2_first;
    logic [DWIDTH-1:0] h1;
    logic [DWIDTH-1:0] h2;
    logic [DWIDTH-1:0] tap1;
    logic [DWIDTH-1:0] tap2;

    // First pixel of a line replicates itself into both history taps.
    assign tap1 = s2_first ? s2_fused : h1;
    assign tap2 = s2_first ? s2_fused : h2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_first <= 1'b0;
            s2_valid <= 1'b0;
            s2_fused <= '0;
            s2_hole  <= 1'b0;
            s2_eol   <= 1'b0;
            s2_first <= 1'b0;
            h1       <= '0;
            h2       <= '0;
        end else if (clken) begin
            if (din_valid)
                s1_first <= col_zero;
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_fused <= fused;
                s2_hole  <= s1_hole;
                s2_eol   <= s1_eol;
                s2_first <= s1_first;
            end
            if (s2_valid) begin
                h2 <= tap1;
                h1 <= s2_fused;
            end
        end
    end

    assign o_valid = s2_valid;
    assign o_dat   = med(tap2, tap1, s2_fused);
    assign o_hole  = s2_hole;
    assign o_eol   = s2_eol;
`else
    assign o_valid = s1_valid;
    assign o_dat   = fused;
    assign o_hole  = s1_hole;
    assign o_eol   = s1_eol;
`endif

    logic [AW-1:0] acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout            <= '0;
            dout_hole       <= 1'b0;
            dout_valid      <= 1'b0;
            dout_eol        <= 1'b0;
            line_hole_cnt   <= '0;
            line_stat_valid <= 1'b0;
            acc             <= '0;
        end else if (clken) begin
            dout_valid      <= o_valid;
            line_stat_valid <= 1'b0;
            if (o_valid) begin
                dout      <= o_dat;
                dout_hole <= o_hole;
                dout_eol  <= o_eol;
                if (o_eol) begin
                    line_hole_cnt   <= acc + AW'(o_hole);
                    line_stat_valid <= 1'b1;
                    acc             <= '0;
                end else begin
                    acc <= acc + AW'(o_hole);
                end
            end
        end
    end

endmodule

// File: tb/tb_disp_fill_median.sv
// Directed/random stream through disp_fill_median with a reference model and
// expected-result queues for pixel outputs and per-line hole statistics.
module tb_disp_fill_median;

    localparam int DW = 7;
    localparam int IW = 640;
    localparam int CW = $clog2(IW);
    localparam int LW = DW + 2;
`ifdef DISP_HMEDIAN_EN
    localparam int LAT_EDGES = 2;
`else
    localparam int LAT_EDGES = 1;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              clken = 1'b0;
    logic              din_valid = 1'b0;
    logic [3*DW+5:0]   din_overall = '0;
    logic [DW-1:0]     dout;
    logic              dout_hole;
    logic              dout_valid;
    logic              dout_eol;
    logic [CW:0]       line_hole_cnt;
    logic              line_stat_valid;

    disp_fill_median #(.DWIDTH(DW), .IMG_WIDTH(IW)) dut (
        .clk             (clk),
        .rst             (rst),
        .clken           (clken),
        .din_overall     (din_overall),
        .din_valid       (din_valid),
        .dout            (dout),
        .dout_hole       (dout_hole),
        .dout_valid      (dout_valid),
        .dout_eol        (dout_eol),
        .line_hole_cnt   (line_hole_cnt),
        .line_stat_valid (line_stat_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_cnt = 0;
    bit adv_last = 1'b0;

    logic [DW+1:0] exp_q[$];
    int            exp_t[$];
    logic [CW:0]   stat_q[$];

    logic [DW-1:0] m_last [3];
    int            m_col;
    int            m_acc;
`ifdef DISP_HMEDIAN_EN
    logic [DW-1:0] m_p1;
    logic [DW-1:0] m_p2;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] sort_med(input logic [DW-1:0] a,
                                               input logic [DW-1:0] b,
                                               input logic [DW-1:0] c);
        logic [DW-1:0] x, y, z, t;
        x = a; y = b; z = c;
        if (x > y) begin t = x; x = y; y = t; end
        if (y > z) begin t = y; y = z; z = t; end
        if (x > y) begin t = x; x = y; y = t; end
        return y;
    endfunction

    function automatic logic [LW-1:0] ln(input logic [1:0] fl, input int d);
        return {fl, DW'(d)};
    endfunction

    function automatic logic [3*LW-1:0] pix(input logic [LW-1:0] l135,
                                            input logic [LW-1:0] l90,
                                            input logic [LW-1:0] l45);
        return {l135, l90, l45};
    endfunction

    function automatic logic [3*LW-1:0] rand_pix(input bit make_hole);
        logic [1:0] fl [3];
        logic [LW-1:0] l [3];
        for (int i = 0; i < 3; i++) begin
            if (make_hole)
                fl[i] = 2'($urandom_range(1, 3));
            else
                fl[i] = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        end
        if (!make_hole && fl[0] != 0 && fl[1] != 0 && fl[2] != 0)
            fl[0] = 2'b00;
        for (int i = 0; i < 3; i++)
            l[i] = ln(fl[i], $urandom_range(0, 127));
        return pix(l[2], l[1], l[0]);
    endfunction

    task automatic model_push(input logic [3*LW-1:0] d);
        logic [DW-1:0] f [3];
        logic [LW-1:0] lane;
        bit            fl_all;
        logic [DW-1:0] m;
        bit            e;
        fl_all = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lane = d[i*LW +: LW];
            if (lane[DW+1:DW] == 2'b00) begin
                f[i] = lane[DW-1:0];
                m_last[i] = lane[DW-1:0];
                fl_all = 1'b0;
            end else begin
                f[i] = (m_col == 0) ? '0 : m_last[i];
            end
        end
        m = sort_med(f[0], f[1], f[2]);
`ifdef DISP_HMEDIAN_EN
        if (m_col == 0) begin m_p1 = m; m_p2 = m; end
        begin
            logic [DW-1:0] cur;
            cur = m;
            m = sort_med(m_p2, m_p1, cur);
            m_p2 = m_p1;
            m_p1 = cur;
        end
`endif
        e = (m_col == IW - 1);
        exp_q.push_back({fl_all, e, m});
        exp_t.push_back(edge_cnt + LAT_EDGES);
        m_acc += int'(fl_all);
        if (e) begin
            stat_q.push_back((CW+1)'(m_acc));
            m_acc = 0;
            m_col = 0;
        end else begin
            m_col++;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_last[i] = '0;
        m_col = 0;
        m_acc = 0;
    endtask

    task automatic drive(input logic [3*LW-1:0] d);
        din_overall = d;
        din_valid   = 1'b1;
        clken       = 1'b1;
        @(posedge clk);
        #1;
        model_push(d);
        din_valid = 1'b0;
    endtask

    task automatic bubble(input int n);
        din_valid = 1'b0;
        clken     = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic stall(input int n);
        clken       = 1'b0;
        din_valid   = 1'b1;
        din_overall = 27'($urandom);
        repeat (n) @(posedge clk);
        #1;
        clken     = 1'b1;
        din_valid = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_dout", dout, 0);
        check("rst_dout_hole", dout_hole, 0);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_dout_eol", dout_eol, 0);
        check("rst_line_hole_cnt", line_hole_cnt, 0);
        check("rst_line_stat_valid", line_stat_valid, 0);
    endtask

    always @(posedge clk) begin
        adv_last = clken & rst;
        if (clken & rst) edge_cnt++;
    end

    // Only compare outputs produced by an advancing edge; frozen cycles repeat.
    always @(negedge clk) begin
        if (adv_last && rst) begin
            if (dout_valid) begin
                check("out_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    logic [DW+1:0] e;
                    int t;
                    e = exp_q.pop_front();
                    t = exp_t.pop_front();
                    check("dout", dout, e[DW-1:0]);
                    check("dout_hole", dout_hole, e[DW+1]);
                    check("dout_eol", dout_eol, e[DW]);
                    check("latency", edge_cnt, t);
                end
            end
            if (line_stat_valid) begin
                check("stat_pending", stat_q.size() > 0, 1);
                if (stat_q.size() > 0)
                    check("line_hole_cnt", line_hole_cnt, stat_q.pop_front());
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b1;
        bubble(2);

        // Line 1: col 0 all valid 10/20/30.
        drive(pix(ln(2'b00, 30), ln(2'b00, 20), ln(2'b00, 10)));
        bubble(3);
        for (int c = 1; c < 5; c++) drive(rand_pix(1'b0));
        drive(pix(ln(2'b00, 40), ln(2'b00, 40), ln(2'b00, 40)));
        drive(pix(ln(2'b00, 40), ln(2'b01, 3), ln(2'b00, 40)));
        for (int c = 7; c < IW - 1; c++) begin
            if (c == 320) stall(4);
            if (c == 450) bubble(2);
            drive(rand_pix(c == 7 || (c % 100) == 0));
        end
        drive(pix(ln(2'b00, 50), ln(2'b00, 50), ln(2'b00, 50)));

        // Line 2: col 0 all mismatched must not inherit the 50s.
        drive(pix(ln(2'b10, 50), ln(2'b10, 50), ln(2'b10, 50)));
        for (int c = 1; c < IW; c++) drive(rand_pix(c == 320));
        bubble(3);

        // Reset mid-line.
        for (int c = 0; c < 10; c++) drive(rand_pix(1'b0));
        bubble(3);
        clken = 1'b0;
        rst = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        drive(pix(ln(2'b00, 5), ln(2'b00, 5), ln(2'b00, 5)));
        drive(pix(ln(2'b00, 90), ln(2'b00, 90), ln(2'b00, 90)));
        drive(pix(ln(2'b00, 7), ln(2'b00, 7), ln(2'b00, 7)));
        drive(pix(ln(2'b00, 8), ln(2'b00, 8), ln(2'b00, 8)));
        drive(pix(ln(2'b01, 1), ln(2'b10, 2), ln(2'b11, 3)));
        bubble(5);

        check("exp_q_drained", exp_q.size(), 0);
        check("stat_q_drained", stat_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
